// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: instruction constants, default datapath
// width and the big-endian byte-packing helper used by the program loader.
package mips_pkg;

    localparam int          NB_WIDTH_DEFAULT = 32;
    localparam int          NB_BYTE          = 8;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR       = 32'hFFFF_FFFF;

    // Joins the three buffered leading bytes with the final byte (big-endian).
    function automatic logic [31:0] pack_word(input logic [23:0] head,
                                              input logic [7:0]  tail);
        return {head, tail};
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: DEPTH x NB_WIDTH words, one synchronous write port
// (program loader) and one asynchronous read port (fetch). Not reset.
module instr_mem #(
    parameter int NB_WIDTH = 32,
    parameter int DEPTH    = 256,
    parameter int NB_ADDR  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [NB_ADDR-1:0]  i_waddr,
    input  logic [NB_WIDTH-1:0] i_wdata,
    input  logic [NB_ADDR-1:0]  i_raddr,
    output logic [NB_WIDTH-1:0] o_rdata
);

    logic [NB_WIDTH-1:0] r_mem [DEPTH];

    // Store a completed loader word on the edge that accepts its last byte.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: byte-serial program loader, instruction memory
// and the IF/ID pipeline register (stall / flush / halt aware).
// Optional feature macro: IF_HALT_DETECT_EN enables the sticky HALT-word
// detector on o_halt_detected; when undefined that output is tied to 0.
module if_stage
    import mips_pkg::*;
#(
    parameter int NB_WIDTH   = NB_WIDTH_DEFAULT,
    parameter int IMEM_DEPTH = 256,
    localparam int NB_IADDR  = $clog2(IMEM_DEPTH)
) (
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic [NB_WIDTH-1:0] i_pcounter,
    input  logic [NB_WIDTH-1:0] i_pcounter4,
    input  logic                i_stall,
    input  logic                i_halt,
    input  logic                i_flush,
    input  logic                i_load_en,
    input  logic                i_load_clear,
    input  logic                i_load_valid,
    input  logic [7:0]          i_load_byte,
    output logic [NB_WIDTH-1:0] o_instruction,
    output logic [NB_WIDTH-1:0] o_pcounter4,
    output logic                o_valid,
    output logic [NB_IADDR:0]   o_load_addr,
    output logic                o_load_full,
    output logic                o_halt_detected
);

    localparam logic [NB_IADDR:0] LOAD_LIMIT = (NB_IADDR+1)'(IMEM_DEPTH);
    localparam logic [NB_IADDR:0] LOAD_ONE   = (NB_IADDR+1)'(1);
    localparam logic [NB_WIDTH:0] FETCH_LIMIT = (NB_WIDTH+1)'(4 * IMEM_DEPTH);
    localparam logic [NB_WIDTH-1:0] NOP_WORD  = NB_WIDTH'(NOP_INSTR);

    // Loader state
    logic [1:0]          r_byte_cnt;
    logic [23:0]         r_byte_buf;
    logic [NB_IADDR:0]   r_load_addr;
    logic                r_load_full;

    // IF/ID register
    logic [NB_WIDTH-1:0] r_instruction;
    logic [NB_WIDTH-1:0] r_pcounter4;
    logic                r_valid;

    logic                w_byte_accept;
    logic                w_word_done;
    logic [NB_IADDR:0]   w_load_addr_inc;
    logic [NB_WIDTH-1:0] w_wdata;
    logic [NB_WIDTH-1:0] w_mem_rdata;
    logic [NB_IADDR-1:0] w_fetch_index;
    logic                w_fetch_oor;
    logic [NB_WIDTH-1:0] w_fetch_word;
    logic                w_unused_pc_lsbs;

    assign w_byte_accept    = i_load_en & i_load_valid & ~r_load_full;
    assign w_word_done      = w_byte_accept & (r_byte_cnt == 2'd3);
    assign w_load_addr_inc  = r_load_addr + LOAD_ONE;
    assign w_wdata          = NB_WIDTH'(pack_word(r_byte_buf, i_load_byte));
    assign w_fetch_index    = i_pcounter[NB_IADDR+1:2];
    assign w_fetch_oor      = ({1'b0, i_pcounter} >= FETCH_LIMIT);
    // Byte-offset bits of the PC have no meaning for word fetch.
    assign w_unused_pc_lsbs = ^i_pcounter[1:0];

    instr_mem #(
        .NB_WIDTH (NB_WIDTH),
        .DEPTH    (IMEM_DEPTH),
        .NB_ADDR  (NB_IADDR)
    ) u_instr_mem (
        .clk      (clk),
        .i_we     (w_word_done),
        .i_waddr  (r_load_addr[NB_IADDR-1:0]),
        .i_wdata  (w_wdata),
        .i_raddr  (w_fetch_index),
        .o_rdata  (w_mem_rdata)
    );

    // Addresses beyond the memory fetch a NOP instead of aliasing.
    always_comb begin
        w_fetch_word = NOP_WORD;
        if (w_fetch_oor) begin
            w_fetch_word = NOP_WORD;
        end else begin
            w_fetch_word = w_mem_rdata;
        end
    end

    // Loader: assemble bytes big-endian, write each full word, stop when full.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_cnt  <= 2'd0;
            r_byte_buf  <= 24'h00_0000;
            r_load_addr <= '0;
            r_load_full <= 1'b0;
        end else if (i_load_clear) begin
            r_byte_cnt  <= 2'd0;
            r_load_addr <= '0;
            r_load_full <= 1'b0;
        end else if (!i_load_en) begin
            // Leaving loader mode drops any partially assembled word.
            r_byte_cnt  <= 2'd0;
        end else if (w_byte_accept) begin
            case (r_byte_cnt)
                2'd0:    r_byte_buf[23:16] <= i_load_byte;
                2'd1:    r_byte_buf[15:8]  <= i_load_byte;
                2'd2:    r_byte_buf[7:0]   <= i_load_byte;
                2'd3: begin
                    r_load_addr <= w_load_addr_inc;
                    r_load_full <= (w_load_addr_inc == LOAD_LIMIT);
                end
                default: r_byte_buf <= r_byte_buf;
            endcase
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end
    end

    // IF/ID register: loader and flush insert bubbles, halt/stall hold.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instruction <= NOP_WORD;
            r_pcounter4   <= '0;
            r_valid       <= 1'b0;
        end else if (i_load_en || i_flush) begin
            r_instruction <= NOP_WORD;
            r_pcounter4   <= '0;
            r_valid       <= 1'b0;
        end else if (i_halt || i_stall) begin
            r_instruction <= r_instruction;
            r_pcounter4   <= r_pcounter4;
            r_valid       <= r_valid;
        end else begin
            r_instruction <= w_fetch_word;
            r_pcounter4   <= i_pcounter4;
            r_valid       <= 1'b1;
        end
    end

`ifdef IF_HALT_DETECT_EN
    logic r_halt_detected;
    logic w_fetch_commit;

    assign w_fetch_commit = ~i_load_en & ~i_flush & ~i_halt & ~i_stall;

    // Sticky flag raised when a real fetch loads the HALT word.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_halt_detected <= 1'b0;
        end else if (i_load_clear) begin
            r_halt_detected <= 1'b0;
        end else if (w_fetch_commit && (w_fetch_word == NB_WIDTH'(HALT_INSTR))) begin
            r_halt_detected <= 1'b1;
        end else begin
            r_halt_detected <= r_halt_detected;
        end
    end

    assign o_halt_detected = r_halt_detected;
`else
    assign o_halt_detected = 1'b0;
`endif

    assign o_instruction = r_instruction;
    assign o_pcounter4   = r_pcounter4;
    assign o_valid       = r_valid;
    assign o_load_addr   = r_load_addr;
    assign o_load_full   = r_load_full;

endmodule
